mux_scan_sel: RTL and testbench
===============================

MUX_SCAN_SEL -- requirements
Module: mux_scan_sel

Interface
REQ-001 Parameter N_CH, default 8, channel count; power of two, 2..64.
REQ-002 Parameter DW, default 1, data width per channel in bits.
REQ-003 Parameter DWELL, default 4, cycles spent on each channel in scan mode; range 1..255.
REQ-004 Derived constant SW = clog2(N_CH), select width; not user-settable.
REQ-005 clk  input  1  the block's only clock; every register updates on the rising edge.
REQ-006 rst  input  1  synchronous, active-high reset, sampled on the clk rising edge.
REQ-007 din  input  N_CH*DW  packed channel data; channel k occupies bits [k*DW+DW-1 : k*DW].
REQ-008 sel  input  SW  channel select used in manual mode.
REQ-009 mode  input  1  0 = manual, 1 = scan.
REQ-010 start  input  1  single-cycle pulse that starts a scan; acted on only in scan mode.
REQ-011 dout  output  DW  registered selected channel data.
REQ-012 ch_out  output  SW  index of the channel currently in dout.
REQ-013 valid  output  1  dout/ch_out hold a new qualified sample this cycle.
REQ-014 busy  output  1  high while a scan is in progress.
REQ-015 done  output  1  single-cycle pulse when a scan completes.

Function
REQ-016 FSM states: IDLE, SCAN, FIN; encoding is implementation-defined.
REQ-017 Manual mode (mode=0, state IDLE): dout <= din[sel], ch_out <= sel, valid <= 1 every cycle; one-cycle latency from sel/din to dout.
REQ-018 IDLE to SCAN: mode=1 and start=1; channel counter <= 0, dwell counter <= 0, busy <= 1 on the next cycle.
REQ-019 In IDLE with mode=1 and no start: dout and ch_out hold, valid = 0.
REQ-020 SCAN: dwell counter increments every cycle; on dwell count DWELL-1, dout <= din[channel], ch_out <= channel, valid pulses for 1 cycle, dwell counter clears, channel increments.
REQ-021 Sample point: din is sampled on the last dwell cycle of each channel; each channel produces exactly one valid pulse per scan.
REQ-022 After channel N_CH-1 is sampled, go to FIN; FIN asserts done for 1 cycle, clears busy, returns to IDLE.
REQ-023 Scan latency: first valid occurs DWELL cycles after the start-accept edge; done occurs N_CH*DWELL+1 cycles after that edge.
REQ-024 DWELL=1: valid is high on N_CH consecutive cycles.
REQ-025 start while busy is ignored; no restart.
REQ-026 mode dropping to 0 during SCAN aborts the scan: next state IDLE, busy <= 0, no done, no valid for the aborted channel; manual behaviour resumes the following cycle.
REQ-027 start with mode=0 is ignored.
REQ-028 Channel counter never exceeds N_CH-1; no wrap-around inside one scan.

Reset
REQ-029 On rst: state IDLE; dout = 0, ch_out = 0, valid = 0, busy = 0, done = 0; both counters = 0.
REQ-030 rst mid-scan takes priority over all other inputs and abandons the scan without a done pulse.
REQ-031 In the cycle after rst deasserts, normal behaviour per REQ-017 or REQ-018 applies.

Structure
REQ-032 Shared package mux_pkg: FSM state typedef, the mode encodings (MODE_MANUAL = 0, MODE_SCAN = 1), and a clog2 function.
REQ-033 One sub-module, mux_n1, is a parametrised combinational N:1 selector (N_CH, DW); it is the successor of mux8_1 and is instantiated once, driven by the sel input or the channel counter.
REQ-034 All outputs are registered; no combinational path runs from an input to an output.

Verification
REQ-035 Manual mode, N_CH=8, DW=1, din = 8'b11110110, sweep sel 0 to 7 -> dout one cycle later = 0,1,1,0,1,1,1,1, with valid = 1 throughout.
REQ-036 Scan mode, DWELL=4, same din, start pulse -> valid pulses at cycles 4, 8, ..., 32 after accept with ch_out = 0..7 and the dout values above; done at cycle 33; busy low afterwards.
REQ-037 start pulsed again at cycle 10 of a scan -> ignored; the pulse sequence is identical to REQ-036.
REQ-038 mode set to 0 at cycle 13 of a scan -> busy = 0 next cycle, no done; manual output follows sel the cycle after.
REQ-039 rst asserted at cycle 20 of a scan -> all outputs 0 next cycle; a new start after rst deasserts gives a full, correct scan.
REQ-040 Parameter sweep N_CH=4, DW=8, DWELL=1, din = {8'hD4, 8'hC3, 8'hB2, 8'hA1} -> 4 consecutive valid cycles with dout = A1, B2, C3, D4, then done.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared types and constants for the scanning channel selector.
package mux_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StFin
    } state_e;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(n)) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_scan_sel_if.sv
// Channel data, control and result signals of the scanning selector.
interface mux_scan_sel_if
    import mux_pkg::*;
#(
    parameter int unsigned N_CH = 8,
    parameter int unsigned DW   = 1
) ();
    localparam int unsigned SW = clog2(N_CH);

    logic [N_CH*DW-1:0] din;
    logic [SW-1:0]      sel;
    logic               mode;
    logic               start;
    logic [DW-1:0]      dout;
    logic [SW-1:0]      ch_out;
    logic               valid;
    logic               busy;
    logic               done;

    modport master (
        output din, sel, mode, start,
        input  dout, ch_out, valid, busy, done
    );

    modport slave (
        input  din, sel, mode, start,
        output dout, ch_out, valid, busy, done
    );
endinterface

// File: rtl/mux_n1.sv
// Parametrised combinational N:1 selector over a packed channel bus.
module mux_n1
    import mux_pkg::*;
#(
    parameter int unsigned N_CH = 8,
    parameter int unsigned DW   = 1,
    localparam int unsigned SW  = clog2(N_CH)
) (
    input  logic [N_CH*DW-1:0] din_i,
    input  logic [SW-1:0]      sel_i,
    output logic [DW-1:0]      dout_o
);

    always_comb begin
        dout_o = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            if (sel_i == SW'(k)) begin
                dout_o = din_i[k*DW +: DW];
            end
        end
    end

endmodule

// File: rtl/mux_scan_sel.sv
// Channel selector with manual select and a timed scan over all channels.
module mux_scan_sel
    import mux_pkg::*;
#(
    parameter int unsigned N_CH  = 8,
    parameter int unsigned DW    = 1,
    parameter int unsigned DWELL = 4
) (
    input logic           clk,
    input logic           rst,
    mux_scan_sel_if.slave bus
);

    localparam int unsigned SW         = clog2(N_CH);
    localparam logic [7:0]  DWELL_LAST = 8'(DWELL - 1);
    localparam logic [SW-1:0] CH_LAST  = SW'(N_CH - 1);

    state_e          state_q, state_d;
    logic [SW-1:0]   chan_q, chan_d;
    logic [7:0]      dwell_q, dwell_d;
    logic [DW-1:0]   dout_q, dout_d;
    logic [SW-1:0]   ch_q, ch_d;
    logic            valid_q, valid_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [SW-1:0]   mux_sel;
    logic [DW-1:0]   mux_out;

    // The single selector is shared: scan steers it with the channel counter.
    assign mux_sel = (state_q == StScan) ? chan_q : bus.sel;

    mux_n1 #(
        .N_CH (N_CH),
        .DW   (DW)
    ) u_mux (
        .din_i  (bus.din),
        .sel_i  (mux_sel),
        .dout_o (mux_out)
    );

    always_comb begin
        state_d = state_q;
        chan_d  = chan_q;
        dwell_d = dwell_q;
        dout_d  = dout_q;
        ch_d    = ch_q;
        valid_d = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.mode == MODE_MANUAL) begin
                    dout_d  = mux_out;
                    ch_d    = bus.sel;
                    valid_d = 1'b1;
                end else if (bus.start) begin
                    state_d = StScan;
                    chan_d  = '0;
                    dwell_d = '0;
                    busy_d  = 1'b1;
                end
            end
            StScan: begin
                if (bus.mode == MODE_MANUAL) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                end else if (dwell_q == DWELL_LAST) begin
                    dout_d  = mux_out;
                    ch_d    = chan_q;
                    valid_d = 1'b1;
                    dwell_d = '0;
                    if (chan_q == CH_LAST) begin
                        state_d = StFin;
                    end else begin
                        chan_d = chan_q + SW'(1);
                    end
                end else begin
                    dwell_d = dwell_q + 8'd1;
                end
            end
            StFin: begin
                state_d = StIdle;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            chan_q  <= '0;
            dwell_q <= '0;
            dout_q  <= '0;
            ch_q    <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            chan_q  <= chan_d;
            dwell_q <= dwell_d;
            dout_q  <= dout_d;
            ch_q    <= ch_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.dout   = dout_q;
    assign bus.ch_out = ch_q;
    assign bus.valid  = valid_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;

endmodule

// File: tb/tb_mux_scan_sel.sv
// Directed bench: 8x1-bit scanner (DWELL=4) and 4x8-bit scanner (DWELL=1).
module tb_mux_scan_sel;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    int         man_exp [8] = '{0, 1, 1, 0, 1, 1, 1, 1};
    logic [7:0] b_exp   [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};

    always #5 clk = ~clk;

    mux_scan_sel_if #(.N_CH(8), .DW(1)) bus_a ();
    mux_scan_sel_if #(.N_CH(4), .DW(8)) bus_b ();

    mux_scan_sel #(.N_CH(8), .DW(1), .DWELL(4)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    mux_scan_sel #(.N_CH(4), .DW(8), .DWELL(1)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Full scan on DUT A; optionally re-pulse start at cycle restart_at.
    task automatic scan_a(input string name, input int restart_at);
        bit exp_v;
        bus_a.start = 1'b1;
        tick();
        check({name, " accept busy"}, 32'(bus_a.busy), 1);
        check({name, " accept valid"}, 32'(bus_a.valid), 0);
        bus_a.start = 1'b0;
        for (int c = 1; c <= 34; c++) begin
            tick();
            exp_v = (c % 4 == 0) && (c <= 32);
            check($sformatf("%s c%0d valid", name, c), 32'(bus_a.valid), 32'(exp_v));
            check($sformatf("%s c%0d done", name, c), 32'(bus_a.done), 32'(c == 33));
            check($sformatf("%s c%0d busy", name, c), 32'(bus_a.busy), 32'(c <= 32));
            if (exp_v) begin
                check($sformatf("%s c%0d ch", name, c), 32'(bus_a.ch_out), 32'(c / 4 - 1));
                check($sformatf("%s c%0d dout", name, c), 32'(bus_a.dout),
                      32'(man_exp[c / 4 - 1]));
            end
            bus_a.start = (c == restart_at);
        end
        check({name, " hold ch"}, 32'(bus_a.ch_out), 7);
        check({name, " hold dout"}, 32'(bus_a.dout), 1);
    endtask

    initial begin
        rst          = 1'b1;
        bus_a.din    = 8'b1111_0110;
        bus_a.sel    = '0;
        bus_a.mode   = 1'b0;
        bus_a.start  = 1'b0;
        bus_b.din    = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
        bus_b.sel    = '0;
        bus_b.mode   = 1'b1;
        bus_b.start  = 1'b0;
        tick();
        tick();
        check("rst dout", 32'(bus_a.dout), 0);
        check("rst ch", 32'(bus_a.ch_out), 0);
        check("rst valid", 32'(bus_a.valid), 0);
        check("rst busy", 32'(bus_a.busy), 0);
        check("rst done", 32'(bus_a.done), 0);
        check("rst b valid", 32'(bus_b.valid), 0);

        // Manual sweep
        rst = 1'b0;
        for (int s = 0; s < 8; s++) begin
            bus_a.sel = 3'(s);
            tick();
            check($sformatf("man s%0d dout", s), 32'(bus_a.dout), 32'(man_exp[s]));
            check($sformatf("man s%0d ch", s), 32'(bus_a.ch_out), 32'(s));
            check($sformatf("man s%0d valid", s), 32'(bus_a.valid), 1);
        end

        // start in manual mode is ignored
        bus_a.sel   = 3'd1;
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        check("man start busy", 32'(bus_a.busy), 0);
        check("man start valid", 32'(bus_a.valid), 1);
        tick();
        check("man start busy2", 32'(bus_a.busy), 0);

        // Idle in scan mode without start: hold, valid low
        bus_a.mode = 1'b1;
        bus_a.sel  = 3'd3;
        tick();
        check("idle scan valid", 32'(bus_a.valid), 0);
        check("idle scan ch", 32'(bus_a.ch_out), 1);

        scan_a("scan", 0);
        scan_a("restart", 10);

        // Abort by dropping mode mid-scan
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        for (int c = 1; c <= 13; c++) begin
            tick();
        end
        bus_a.mode = 1'b0;
        bus_a.sel  = 3'd3;
        tick();
        check("abort busy", 32'(bus_a.busy), 0);
        check("abort valid", 32'(bus_a.valid), 0);
        check("abort done", 32'(bus_a.done), 0);
        tick();
        check("abort man valid", 32'(bus_a.valid), 1);
        check("abort man ch", 32'(bus_a.ch_out), 3);
        check("abort man dout", 32'(bus_a.dout), 0);
        check("abort man done", 32'(bus_a.done), 0);
        bus_a.sel = 3'd5;
        tick();
        check("abort man ch5", 32'(bus_a.ch_out), 5);
        check("abort man dout5", 32'(bus_a.dout), 1);
        check("abort late done", 32'(bus_a.done), 0);

        // Reset mid-scan
        bus_a.mode  = 1'b1;
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            tick();
        end
        check("pre-rst valid", 32'(bus_a.valid), 1);
        check("pre-rst ch", 32'(bus_a.ch_out), 4);
        rst = 1'b1;
        tick();
        check("midrst dout", 32'(bus_a.dout), 0);
        check("midrst ch", 32'(bus_a.ch_out), 0);
        check("midrst valid", 32'(bus_a.valid), 0);
        check("midrst busy", 32'(bus_a.busy), 0);
        check("midrst done", 32'(bus_a.done), 0);
        rst = 1'b0;
        scan_a("postrst", 0);

        // DUT B: DWELL=1, four consecutive samples then done
        bus_b.start = 1'b1;
        tick();
        check("b accept busy", 32'(bus_b.busy), 1);
        bus_b.start = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            tick();
            check($sformatf("b c%0d valid", c), 32'(bus_b.valid), 32'(c <= 4));
            check($sformatf("b c%0d done", c), 32'(bus_b.done), 32'(c == 5));
            check($sformatf("b c%0d busy", c), 32'(bus_b.busy), 32'(c <= 4));
            if (c <= 4) begin
                check($sformatf("b c%0d dout", c), 32'(bus_b.dout), 32'(b_exp[c - 1]));
                check($sformatf("b c%0d ch", c), 32'(bus_b.ch_out), 32'(c - 1));
            end
        end
        tick();
        check("b after done", 32'(bus_b.done), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
